// File: rtl/pb_mem_tile_arbiter.sv
// pb_mem_tile_arbiter
//   Shares the single-port L2 SPM macro of a mem tile between NumReq NoC-side
//   requesters. Round-robin arbitration with bounded burst locking, fixed
//   latency response routing, optional zero-fill of the SPM after reset.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/ready_o    per-requester handshake (ready is the grant)
//   req_lock_i             requester asks to keep the grant next cycle
//   req_addr/we/wdata/be_i per-requester access fields, packed by index
//   rsp_valid_o            per-requester response strobe, ReadLatency after accept
//   rsp_rdata_o            shared read data, zero unless a response is valid
//   mem_*_o / mem_rdata_i  SPM macro interface
//   init_done_o            high once zero-fill is finished
module pb_mem_tile_arbiter #(
   parameter int NumReq      = 2,
   parameter int AddrWidth   = 16,
   parameter int DataWidth   = 64,
   parameter int NumWords    = 1024,
   parameter int ReadLatency = 1,
   parameter int MaxLock     = 8,
   parameter int ZeroInit    = 1
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NumReq-1:0]                 req_valid_i,
   output logic [NumReq-1:0]                 req_ready_o,
   input  logic [NumReq-1:0]                 req_lock_i,
   input  logic [NumReq*AddrWidth-1:0]       req_addr_i,
   input  logic [NumReq-1:0]                 req_we_i,
   input  logic [NumReq*DataWidth-1:0]       req_wdata_i,
   input  logic [NumReq*(DataWidth/8)-1:0]   req_be_i,
   output logic [NumReq-1:0]                 rsp_valid_o,
   output logic [DataWidth-1:0]              rsp_rdata_o,
   output logic                              mem_req_o,
   output logic [AddrWidth-1:0]              mem_addr_o,
   output logic                              mem_we_o,
   output logic [DataWidth-1:0]              mem_wdata_o,
   output logic [(DataWidth/8)-1:0]          mem_be_o,
   input  logic [DataWidth-1:0]              mem_rdata_i,
   output logic                              init_done_o
);

   localparam int BeWidth  = DataWidth / 8;
   localparam int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int CntWidth = $clog2(MaxLock + 1);

   localparam logic [0:0] INIT      = 1'b0;
   localparam logic [0:0] RUN       = 1'b1;
   localparam logic [0:0] RST_STATE = (ZeroInit != 0) ? INIT : RUN;
   localparam logic [AddrWidth-1:0] LAST_WORD = AddrWidth'(NumWords - 1);

   logic [0:0]           state;
   logic [AddrWidth-1:0] init_cnt;
   logic [IdxWidth-1:0]  ptr;
   logic [CntWidth-1:0]  lock_cnt;
   logic [NumReq-1:0]    rsp_pipe [ReadLatency];

   logic [NumReq-1:0]    ptr_hot;
   logic                 contender;
   logic                 override;
   logic                 gvalid;
   logic [IdxWidth-1:0]  gidx;
   logic [NumReq-1:0]    grant;

   // Arbitration. When the lock budget is spent and someone else waits, the
   // search simply starts one past the locking requester for this decision.
   always_comb begin
      int unsigned start;
      int unsigned idx;
      ptr_hot      = '0;
      ptr_hot[ptr] = 1'b1;
      contender    = |(req_valid_i & ~ptr_hot);
      override     = (lock_cnt == CntWidth'(MaxLock)) && contender;
      start        = {{(32-IdxWidth){1'b0}}, ptr};
      if (override) start = start + 1;
      if (start >= NumReq) start = start - NumReq;
      gvalid = 1'b0;
      gidx   = '0;
      idx    = 0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         idx = start + k;
         if (idx >= NumReq) idx = idx - NumReq;
         if (!gvalid && req_valid_i[idx[IdxWidth-1:0]]) begin
            gvalid = 1'b1;
            gidx   = idx[IdxWidth-1:0];
         end
      end
      if (!rst_ni || state != RUN) gvalid = 1'b0;
      grant = '0;
      if (gvalid) grant[gidx] = 1'b1;
   end

   assign req_ready_o = grant;
   assign init_done_o = rst_ni && (state == RUN);

   // SPM port: zero-fill stream during INIT, otherwise the granted requester.
   always_comb begin
      mem_req_o   = 1'b0;
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (rst_ni && state == INIT) begin
         mem_req_o  = 1'b1;
         mem_we_o   = 1'b1;
         mem_be_o   = '1;
         mem_addr_o = init_cnt;
      end else begin
         for (int unsigned k = 0; k < NumReq; k++) begin
            if (grant[k]) begin
               mem_addr_o  = mem_addr_o  | req_addr_i[k*AddrWidth +: AddrWidth];
               mem_we_o    = mem_we_o    | req_we_i[k];
               mem_wdata_o = mem_wdata_o | req_wdata_i[k*DataWidth +: DataWidth];
               mem_be_o    = mem_be_o    | req_be_i[k*BeWidth +: BeWidth];
            end
         end
         mem_req_o = |(req_valid_i & grant);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= RST_STATE;
         init_cnt <= '0;
         ptr      <= '0;
         lock_cnt <= '0;
      end else if (state == INIT) begin
         init_cnt <= init_cnt + 1'b1;
         if (init_cnt == LAST_WORD) state <= RUN;
      end else if (gvalid) begin
         if (req_lock_i[gidx]) begin
            // Locked grant keeps priority; the count only continues for the
            // same holder, and saturates so an uncontended lock never ends.
            ptr <= gidx;
            if (gidx == ptr && !override)
               lock_cnt <= (lock_cnt == CntWidth'(MaxLock)) ? lock_cnt : lock_cnt + 1'b1;
            else
               lock_cnt <= CntWidth'(1);
         end else begin
            ptr      <= (gidx == IdxWidth'(NumReq - 1)) ? '0 : gidx + 1'b1;
            lock_cnt <= '0;
         end
      end else begin
         lock_cnt <= '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned k = 0; k < ReadLatency; k++) rsp_pipe[k] <= '0;
      end else begin
         rsp_pipe[0] <= grant;
         for (int unsigned k = 1; k < ReadLatency; k++) rsp_pipe[k] <= rsp_pipe[k-1];
      end
   end

   assign rsp_valid_o = rsp_pipe[ReadLatency-1];
   assign rsp_rdata_o = (|rsp_valid_o) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_pb_mem_tile_arbiter.sv
// tb_pb_mem_tile_arbiter
//   Self-checking bench for pb_mem_tile_arbiter with a small SPM model, a
//   shadow memory and a rule-level arbitration model.
module tb_pb_mem_tile_arbiter;

   localparam int NR = 2;
   localparam int AW = 16;
   localparam int DW = 64;
   localparam int BW = DW / 8;
   localparam int NW = 16;
   localparam int RL = 2;
   localparam int ML = 8;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic [NR-1:0]   valid, lock, we;
   logic [NR*AW-1:0] addr;
   logic [NR*DW-1:0] wdata;
   logic [NR*BW-1:0] be;
   logic [NR-1:0]   ready, rsp_valid;
   logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
   logic            mem_req, mem_we, init_done;
   logic [AW-1:0]   mem_addr;
   logic [BW-1:0]   mem_be;
   logic            scramble;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pb_mem_tile_arbiter #(
      .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .NumWords(NW),
      .ReadLatency(RL), .MaxLock(ML), .ZeroInit(1)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(valid), .req_ready_o(ready), .req_lock_i(lock),
      .req_addr_i(addr), .req_we_i(we), .req_wdata_i(wdata), .req_be_i(be),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
      .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
      .init_done_o(init_done)
   );

   // SPM macro model: byte-enabled writes, reads return after RL cycles.
   logic [DW-1:0] spm     [NW];
   logic [DW-1:0] rd_pipe [RL];
   always @(posedge clk) begin
      if (scramble) begin
         for (int i = 0; i < NW; i++) spm[i] <= {32'hA5A5_0000 + i, 32'h5A5A_FFFF - i};
      end else if (mem_req && mem_we) begin
         for (int b = 0; b < BW; b++)
            if (mem_be[b]) spm[int'(mem_addr) % NW][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
      rd_pipe[0] <= (mem_req && !mem_we) ? spm[int'(mem_addr) % NW] : '0;
      for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_rdata = rd_pipe[RL-1];

   // Reference model state
   int            m_rr, m_holder, m_run;
   logic [NR-1:0] e_v  [RL];
   logic          e_rd [RL];
   logic [DW-1:0] e_d  [RL];
   logic [DW-1:0] ref_mem [NW];

   // Whom the rules say gets the port this cycle (-1 = nobody).
   function automatic int model_pick(input logic [NR-1:0] v);
      int  start;
      bit  others;
      start  = m_rr;
      others = 0;
      for (int i = 0; i < NR; i++) if (i != m_holder && v[i]) others = 1;
      if (m_holder >= 0 && m_run >= ML && others) start = (m_holder + 1) % NR;
      for (int k = 0; k < NR; k++) if (v[(start + k) % NR]) return (start + k) % NR;
      return -1;
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                           input logic [BW-1:0] b);
      logic [DW-1:0] r;
      r = old;
      for (int i = 0; i < BW; i++) if (b[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_rr = 0; m_holder = -1; m_run = 0;
      for (int k = 0; k < RL; k++) begin e_v[k] = '0; e_rd[k] = 1'b0; e_d[k] = '0; end
      for (int i = 0; i < NW; i++) ref_mem[i] = '0;
   endtask

   task automatic set_req(input int i, input bit v, input bit l, input bit w, input int a,
                          input logic [DW-1:0] d, input logic [BW-1:0] b);
      valid[i] = v; lock[i] = l; we[i] = w;
      addr[i*AW +: AW] = AW'(a);
      wdata[i*DW +: DW] = d;
      be[i*BW +: BW] = b;
   endtask

   task automatic set_random(input int i);
      set_req(i, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, NW - 1), {$urandom, $urandom}, BW'($urandom));
   endtask

   // Commit the current cycle to the model, then move to the next sample point.
   task automatic advance();
      int g;
      int a;
      g = model_pick(valid);
      for (int k = RL - 1; k > 0; k--) begin e_v[k] = e_v[k-1]; e_rd[k] = e_rd[k-1]; e_d[k] = e_d[k-1]; end
      e_v[0] = '0; e_rd[0] = 1'b0; e_d[0] = '0;
      if (g >= 0) begin
         a = int'(addr[g*AW +: AW]) % NW;
         e_v[0][g] = 1'b1;
         e_rd[0]   = !we[g];
         e_d[0]    = ref_mem[a];
         if (we[g]) ref_mem[a] = merge(ref_mem[a], wdata[g*DW +: DW], be[g*BW +: BW]);
         if (lock[g]) begin
            m_run = (g == m_holder) ? m_run + 1 : 1;
            m_holder = g; m_rr = g;
         end else begin
            m_holder = -1; m_run = 0; m_rr = (g + 1) % NR;
         end
      end else begin
         m_holder = -1; m_run = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      valid = '1; lock = '0;
      #1;
      total++;
      if ({ready, rsp_valid, mem_req, init_done} !== '0 || rsp_rdata !== '0) begin
         bad++;
         $display("FAIL reset_outputs ready=%b rsp=%b mem_req=%b done=%b rdata=%h exp all 0",
                  ready, rsp_valid, mem_req, init_done, rsp_rdata);
      end
      @(negedge clk);
      rst_ni = 1'b1;
      for (int i = 0; i < NW; i++) begin
         #1;
         total++;
         if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, ready, rsp_valid, init_done} !==
             {1'b1, 1'b1, AW'(i), {DW{1'b0}}, {BW{1'b1}}, {NR{1'b0}}, {NR{1'b0}}, 1'b0}) begin
            bad++;
            $display("FAIL init_cycle%0d req=%b we=%b addr=%0d wdata=%h be=%h ready=%b rsp=%b done=%b exp 1 1 %0d 0 ff 0 0 0",
                     i, mem_req, mem_we, mem_addr, mem_wdata, mem_be, ready, rsp_valid, init_done, i);
         end
         @(negedge clk);
      end
      valid = '0;
      #1;
      total++;
      if (init_done !== 1'b1 || rsp_valid !== '0 || mem_req !== 1'b0) begin
         bad++;
         $display("FAIL init_done done=%b rsp=%b mem_req=%b exp 1 0 0", init_done, rsp_valid, mem_req);
      end
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int g;
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < NR; i++) set_req(i, 1, 0, 0, $urandom_range(0, NW - 1), '0, '1);
         #1;
         g = model_pick(valid);
         total++;
         if (ready !== ((g >= 0) ? NR'(1) << g : NR'(0))) begin
            bad++; $display("FAIL rr_grant cyc=%0d got=%b exp_idx=%0d", c, ready, g);
         end
         total++;
         if (rsp_valid !== e_v[RL-1]) begin
            bad++; $display("FAIL rr_rsp cyc=%0d got=%b exp=%b", c, rsp_valid, e_v[RL-1]);
         end
         advance();
      end
      valid = '0;
   endtask

   task automatic test_write_read();
      bit seen;
      set_req(1, 1, 0, 1, 5, 64'hFFFF_FFFF_DEAD_BEEF, 8'h0F);
      #1;
      total++;
      if (ready !== 2'b10 || mem_addr !== AW'(5) || mem_we !== 1'b1 || mem_be !== 8'h0F) begin
         bad++; $display("FAIL wr_issue ready=%b addr=%0d we=%b be=%h exp 10 5 1 0f", ready, mem_addr, mem_we, mem_be);
      end
      advance();
      valid[1] = 1'b0;
      set_req(0, 1, 0, 0, 5, '0, '1);
      #1;
      total++;
      if (ready !== 2'b01 || mem_we !== 1'b0) begin
         bad++; $display("FAIL rd_issue ready=%b we=%b exp 01 0", ready, mem_we);
      end
      advance();
      valid = '0;
      seen = 0;
      for (int c = 0; c < RL + 2; c++) begin
         #1;
         total++;
         if (rsp_valid !== e_v[RL-1]) begin
            bad++; $display("FAIL wr_rd_rsp cyc=%0d got=%b exp=%b", c, rsp_valid, e_v[RL-1]);
         end
         if (e_v[RL-1] == 2'b01) begin
            seen = 1;
            total++;
            if (rsp_rdata !== 64'h0000_0000_DEAD_BEEF) begin
               bad++; $display("FAIL rd_data got=%h exp=00000000deadbeef", rsp_rdata);
            end
         end
         advance();
      end
      total++;
      if (!seen) begin bad++; $display("FAIL rd_rsp_seen got=0 exp=1"); end
   endtask

   task automatic test_lock();
      int g, run, longest;
      run = 0; longest = 0;
      for (int c = 0; c < 30; c++) begin
         set_req(0, 1, 1, 0, $urandom_range(0, NW - 1), '0, '1);
         set_req(1, 1, 0, 0, $urandom_range(0, NW - 1), '0, '1);
         #1;
         g = model_pick(valid);
         total++;
         if (ready !== ((g >= 0) ? NR'(1) << g : NR'(0))) begin
            bad++; $display("FAIL lock_grant cyc=%0d got=%b exp_idx=%0d", c, ready, g);
         end
         if (ready == 2'b01) run++; else run = 0;
         if (run > longest) longest = run;
         advance();
      end
      valid = '0;
      total++;
      if (longest != ML) begin bad++; $display("FAIL lock_burst got=%0d exp=%0d", longest, ML); end
   endtask

   task automatic test_lock_no_contender();
      bit found;
      for (int c = 0; c < 20; c++) begin
         set_req(0, 1, 1, 1, c % NW, {$urandom, $urandom}, '1);
         valid[1] = 1'b0;
         #1;
         total++;
         if (ready !== 2'b01) begin bad++; $display("FAIL solo_lock cyc=%0d got=%b exp=01", c, ready); end
         advance();
      end
      found = 0;
      for (int c = 0; c < ML + 1 && !found; c++) begin
         set_req(0, 1, 1, 0, 0, '0, '1);
         set_req(1, 1, 0, 0, 1, '0, '1);
         #1;
         if (ready[1] === 1'b1) found = 1;
         advance();
      end
      valid = '0;
      total++;
      if (!found) begin bad++; $display("FAIL contender_wait got=no_grant exp=grant within %0d", ML + 1); end
   endtask

   task automatic test_random(input int n);
      int g;
      for (int c = 0; c < n; c++) begin
         for (int i = 0; i < NR; i++) set_random(i);
         #1;
         g = model_pick(valid);
         total++;
         if (ready !== ((g >= 0) ? NR'(1) << g : NR'(0)) || mem_req !== (g >= 0)) begin
            bad++; $display("FAIL rnd_grant cyc=%0d ready=%b mem_req=%b exp_idx=%0d", c, ready, mem_req, g);
         end
         if (g >= 0) begin
            total++;
            if ({mem_addr, mem_we, mem_wdata, mem_be} !==
                {addr[g*AW +: AW], we[g], wdata[g*DW +: DW], be[g*BW +: BW]}) begin
               bad++; $display("FAIL rnd_fields cyc=%0d addr=%0d we=%b wdata=%h be=%h exp %0d %b %h %h",
                               c, mem_addr, mem_we, mem_wdata, mem_be, addr[g*AW +: AW], we[g],
                               wdata[g*DW +: DW], be[g*BW +: BW]);
            end
         end
         total++;
         if (rsp_valid !== e_v[RL-1]) begin
            bad++; $display("FAIL rnd_rsp cyc=%0d got=%b exp=%b", c, rsp_valid, e_v[RL-1]);
         end
         if (e_v[RL-1] == '0) begin
            total++;
            if (rsp_rdata !== '0) begin bad++; $display("FAIL rnd_idle_data cyc=%0d got=%h exp=0", c, rsp_rdata); end
         end else if (e_rd[RL-1]) begin
            total++;
            if (rsp_rdata !== e_d[RL-1]) begin
               bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, rsp_rdata, e_d[RL-1]);
            end
         end
         advance();
      end
      valid = '0;
   endtask

   task automatic test_reset_mid();
      set_req(0, 1, 0, 0, 3, '0, '1);
      valid[1] = 1'b0;
      #1;
      total++;
      if (ready !== 2'b01) begin bad++; $display("FAIL mid_issue got=%b exp=01", ready); end
      advance();
      test_reset();
      for (int c = 0; c < RL + 2; c++) begin
         #1;
         total++;
         if (rsp_valid !== '0) begin bad++; $display("FAIL mid_rsp cyc=%0d got=%b exp=00", c, rsp_valid); end
         advance();
      end
   endtask

   initial begin
      rst_ni = 1'b0; scramble = 1'b1;
      valid = '0; lock = '0; we = '0; addr = '0; wdata = '0; be = '0;
      model_reset();
      @(posedge clk); #1 scramble = 1'b0;
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_write_read();
      test_lock();
      test_lock_no_contender();
      test_random(400);
      test_reset_mid();
      test_random(150);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pb_mem_tile_arbiter.md
Name: pb_mem_tile_arbiter

Overview:
Shares the single-port L2 SPM macro of a picobello mem tile between NumReq NoC-side requesters, e.g. narrow and wide AXI-to-mem adapters.
- Round-robin arbitration with bounded burst locking.
- Fixed-latency response routing back to the requester that issued each access.
- Optional zero-fill of the whole SPM after reset, before any requester is served.
- Sits between the FlooNoC chimney memory adapters and the SPM bank, inside the mem tile.

Parameters:
NumReq, 2, number of requesters; index 0 is the highest initial round-robin priority.
AddrWidth, 16, word-address width into the SPM.
DataWidth, 64, SPM word width in bits; byte enable width is DataWidth/8.
NumWords, 1024, SPM depth in words; must be ≤ 2**AddrWidth.
ReadLatency, 1, cycles from an accepted mem_req_o to valid mem_rdata_i; must be ≥ 1.
MaxLock, 8, maximum consecutive grants to one locking requester while others wait.
ZeroInit, 1, when 1, zero-fill the SPM after reset.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NumReq  per-requester access request
req_ready_o  out  NumReq  grant; an access transfers when valid & ready
req_lock_i  in  NumReq  requester asks to keep the grant next cycle (burst)
req_addr_i  in  NumReq*AddrWidth  word address
req_we_i  in  NumReq  1 = write, 0 = read
req_wdata_i  in  NumReq*DataWidth  write data
req_be_i  in  NumReq*DataWidth/8  byte enables
rsp_valid_o  out  NumReq  response strobe (read data or write ack); no backpressure
rsp_rdata_o  out  DataWidth  read data, shared by all requesters, qualified by rsp_valid_o
mem_req_o  out  1  SPM access
mem_addr_o  out  AddrWidth  SPM address
mem_we_o  out  1  SPM write enable
mem_wdata_o  out  DataWidth  SPM write data
mem_be_o  out  DataWidth/8  SPM byte enables
mem_rdata_i  in  DataWidth  SPM read data
init_done_o  out  1  high once zero-fill is complete; stays high until the next reset

Behaviour:
Reset values:
- All outputs are 0.
- Round-robin pointer = 0; lock counter = 0; response pipe empty; init counter = 0.

FSM states: INIT, RUN.
- Reset enters INIT if ZeroInit = 1, otherwise RUN.

INIT:
- Every cycle: mem_req_o = 1, mem_we_o = 1, mem_be_o = all ones, mem_wdata_o = 0, mem_addr_o = counter.
- req_ready_o = 0.
- After the write to address NumWords-1, go to RUN. INIT lasts exactly NumWords cycles.
- Zero-fill writes produce no rsp_valid_o.

RUN:
- init_done_o = 1.
- Grant is combinational within the cycle: at most one bit of req_ready_o is set, and it is only set for a requester with valid = 1.
- The mem_* outputs mirror the granted requester's fields in the same cycle; mem_req_o = |(req_valid_i & req_ready_o).
- Round-robin: search starts at the pointer. After a grant to requester i with lock = 0, the pointer becomes (i+1) mod NumReq.
- Lock:
  - If the granted requester has lock = 1, it keeps priority next cycle and the pointer is unchanged.
  - The lock counter increments on every locked grant and clears when a grant goes to a different requester or lock drops.
  - When the counter reaches MaxLock and another requester has valid = 1, the lock is ignored for that decision: the pointer advances and the counter clears.
  - With no contender, locking is unbounded.
- Response pipe: a ReadLatency-deep shift register of {valid, one-hot requester id} records every accepted access.
  - rsp_valid_o[id] pulses exactly ReadLatency cycles after acceptance, for both reads and writes.
  - rsp_rdata_o = mem_rdata_i when any rsp_valid_o is high, otherwise 0.
- Throughput: one access per cycle, back-to-back, with no bubbles between requesters.
- A request dropping valid while locked releases the lock; no grant is issued to an idle requester.

Reset mid-operation: pending responses are discarded and INIT restarts from address 0.

Test Plan:
- ZeroInit = 1, NumWords = 16: release reset → mem_we_o high for exactly 16 cycles, addresses 0..15, wdata 0; init_done_o rises in cycle 16; no rsp_valid_o pulses.
- RUN, requesters 0 and 1 both valid continuously, lock = 0 → grants alternate 0,1,0,1; each rsp_valid_o[i] pulses ReadLatency = 1 cycle after its grant.
- Requester 1 writes 0xDEADBEEF to address 5 with be = 0x0F, then requester 0 reads address 5 → rsp_rdata_o = 0x00000000DEADBEEF on rsp_valid_o[0].
- Requester 0 holds lock with continuous valid, requester 1 valid, MaxLock = 8 → 8 consecutive grants to 0, then 1 grant to 1, then back to 0.
- Lock with no contender: requester 0 gets 20 consecutive grants; requester 1 asserts valid at cycle 20 → it is granted within MaxLock+1 cycles.
- Assert rst_ni low for one cycle while 1 read is in flight (ReadLatency = 2) → no rsp_valid_o afterwards; INIT restarts at address 0.
